dmem_access_ctrl: RTL and testbench
===================================

# dmem_access_ctrl

Multi-cycle data-memory access controller sitting directly downstream of the ALU in the processor datapath. For LW/SW it takes the effective address from the ALU's load/store adder path (ALUOp 4'b1010), issues a single request to a variable-latency data memory, and freezes the rest of the single-cycle core with a stall signal until the access completes or times out. Read data is held for writeback; non-memory instructions pass through with no added latency.

## Interface
- `TIMEOUT`, default 16: max cycles spent in WAIT before the access is aborted (legal range 2..255).
- `CNT_W`, default 8: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `mem_read`  in  1  current instruction is LW.
- `mem_write`  in  1  current instruction is SW.
- `addr`  in  16  effective address (ALU_Out).
- `wdata`  in  16  store data (register file read port 2).
- `stall`  out  1  freeze PC and register-file writes this cycle.
- `rdata`  out  16  load data, held until the next completed load.
- `rdata_valid`  out  1  one-cycle pulse: `rdata` updated by the access completing this cycle.
- `err`  out  1  one-cycle pulse: access aborted (timeout, misaligned address, or both ops requested).
- `mem_en`  out  1  one-cycle request strobe to the memory.
- `mem_wr`  out  1  1 = write, 0 = read; valid with `mem_en`.
- `mem_addr`  out  16  registered request address.
- `mem_wdata`  out  16  registered store data.
- `mem_rdata`  in  16  memory read data, valid with `mem_valid`.
- `mem_valid`  in  1  memory completion pulse.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - no request: `stall`=0, stay.
  - `mem_read` xor `mem_write`, `addr[0]`=0: `stall`=1 combinationally this cycle; latch `addr`, `wdata`, op; go to REQ.
  - both asserted, or `addr[0]`=1: `stall`=1; no memory access; go to DONE with abort flagged.
  - `mem_valid` is ignored in IDLE.
- REQ: `mem_en`=1 for exactly this cycle; `mem_wr`, `mem_addr`, `mem_wdata` hold the latched values; `stall`=1.
  - `mem_valid`=1 in this cycle: complete immediately (go to DONE).
  - otherwise: clear wait counter, go to WAIT.
- WAIT: `stall`=1; counter increments each cycle.
  - `mem_valid`=1: complete, go to DONE. If `mem_valid` and counter==TIMEOUT coincide, completion wins.
  - counter reaches TIMEOUT: abort, go to DONE.
- Completion of a read: `rdata` <= `mem_rdata` on the completing edge. Completion of a write leaves `rdata` unchanged.
- DONE: `stall`=0, so the core retires the instruction at this cycle's edge. `rdata_valid`=1 if a read completed; `err`=1 if aborted. Request inputs are ignored (same instruction still presented); next state is always IDLE.
- Aborted read: `rdata` <= 16'h0000.
- `mem_addr`/`mem_wdata` hold their last value outside REQ; `mem_en`=0 outside REQ.

## Timing
- Reset (async assert, sync-release use): state=IDLE, counter=0, `rdata`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wr`=0, `mem_en`=0, `rdata_valid`=0, `err`=0, `stall`=0 while `rst_n`=0.
- Reset mid-operation: FSM to IDLE immediately, `mem_en` drops; a late `mem_valid` after reset release is ignored.
- Latency, request seen in cycle T: `mem_en` at T+1; with `mem_valid` at T+1+k (k>=0), DONE at T+2+k; total 3+k cycles; `stall` high T..T+1+k.
- Abort from IDLE (misaligned/double op): `stall` high at T only, DONE at T+1.
- Timeout: DONE at T+2+TIMEOUT with `err`=1.
- Back-to-back memory instructions: the next request is accepted in the IDLE cycle after DONE; there is no overlap.
- Flags from the ALU are not touched; LW/SW do not update Z/V/N.

## Test plan
- Reset: hold `rst_n`=0 with `mem_read`=1 -> `stall`=0, `mem_en`=0, `rdata`=0; release -> `stall`=1 the same cycle.
- Zero-wait load: `mem_read`=1, `addr`=16'h0040; memory returns 16'hBEEF with `mem_valid` in the REQ cycle -> `mem_en` one cycle with `mem_addr`=16'h0040, `mem_wr`=0; DONE on the 3rd cycle with `rdata`=16'hBEEF, `rdata_valid`=1, `stall`=0.
- Store with 4-cycle memory: `mem_write`=1, `addr`=16'h0100, `wdata`=16'h1234, `mem_valid` 4 cycles after `mem_en` -> `mem_wr`=1, `mem_wdata`=16'h1234; `stall` high 6 cycles; `rdata` unchanged; `rdata_valid`=0.
- Timeout: TIMEOUT=16, load with no `mem_valid` -> `err` pulse at DONE 18 cycles after request, `rdata`=0; a late `mem_valid` in IDLE is ignored.
- Illegal: `addr`=16'h0041 with `mem_read`; separately `mem_read`=`mem_write`=1 -> no `mem_en`; `stall` 1 cycle; `err` pulse next cycle.
- Reset mid-WAIT: drop `rst_n` 2 cycles into WAIT -> outputs return to reset values asynchronously; after release, a new load to 16'h0002 completes normally.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: multi-cycle LW/SW controller that stalls the core around a variable-latency data memory access
module dmem_access_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        stall,
  output logic [15:0] rdata,
  output logic        rdata_valid,
  output logic        err,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_valid
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic ab;
  logic req, bad, tmo, busy, tmo_ab;
  assign req    = mem_read | mem_write;
  assign bad    = (mem_read & mem_write) | addr[0];
  assign tmo    = cnt == CNT_W'(TIMEOUT - 1);
  assign busy   = state == REQ || state == WAIT;
  assign tmo_ab = state == WAIT && !mem_valid && tmo;
  // state register; async reset aborts any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // next state: completion beats timeout in the same cycle
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = !req ? IDLE : bad ? DONE : REQ;
      REQ:     state_nx = mem_valid ? DONE : WAIT;
      WAIT:    state_nx = (mem_valid || tmo) ? DONE : WAIT;
      default: state_nx = IDLE;
    endcase
  end
  // outputs: stall is combinational in IDLE so the core freezes in the request cycle
  always_comb begin
    stall       = rst_n & (state == IDLE ? req : state != DONE);
    mem_en      = state == REQ;
    rdata_valid = state == DONE && !ab && !mem_wr;
    err         = state == DONE && ab;
  end
  // datapath: request latch, wait counter, abort flag and load data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      ab        <= 1'b0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wr    <= 1'b0;
    end else begin
      cnt <= state == WAIT ? cnt + CNT_W'(1) : '0;
      if (state == IDLE) ab <= bad;
      else if (busy) ab <= tmo_ab;
      if (state == IDLE && req && !bad) begin
        mem_addr  <= addr;
        mem_wdata <= wdata;
        mem_wr    <= mem_write;
      end
      if (state == IDLE && req && bad && mem_read && !mem_write) rdata <= '0;
      else if (busy && mem_valid && !mem_wr) rdata <= mem_rdata;
      else if (tmo_ab && !mem_wr) rdata <= '0;
    end
  end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: randomized transaction-level check of dmem_access_ctrl against a timing model
module tb_dmem_access_ctrl;
  localparam int TO = 16;
  logic clk = 1'b0, rst_n = 1'b0, mem_read = 1'b0, mem_write = 1'b0, mem_valid = 1'b0;
  logic [15:0] addr = '0, wdata = '0, mem_rdata = '0;
  logic stall, rdata_valid, err, mem_en, mem_wr;
  logic [15:0] rdata, mem_addr, mem_wdata;
  logic [15:0] model_rd = '0;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata),
    .rdata_valid(rdata_valid), .err(err), .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_valid(mem_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      addr      = 16'($urandom);
      wdata     = 16'($urandom);
      mem_valid = 1'($urandom);
      mem_rdata = 16'($urandom);
      #4;
      check("idle_stall", 32'(stall), 32'(0));
      check("idle_mem_en", 32'(mem_en), 32'(0));
      check("idle_err", 32'(err), 32'(0));
      check("idle_rdata_valid", 32'(rdata_valid), 32'(0));
      check("idle_rdata", 32'(rdata), 32'(model_rd));
      step;
    end
  endtask

  // one instruction: k = memory latency after mem_en, -1 = memory never answers
  task automatic run_op(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] d, input int k, input logic [15:0] mr);
    logic legal, tmo, last;
    logic [15:0] old;
    int n;
    legal = (rd ^ wr) && !a[0];
    tmo   = legal && k < 0;
    n     = !legal ? 2 : tmo ? TO + 3 : k + 3;
    old   = model_rd;
    if (rd && !wr) model_rd = (legal && !tmo) ? mr : 16'h0000;
    for (int c = 0; c < n; c++) begin
      mem_read  = rd;
      mem_write = wr;
      addr      = a;
      wdata     = d;
      mem_valid = legal && !tmo && c == 1 + k;
      mem_rdata = mem_valid ? mr : 16'($urandom);
      #4;
      last = c == n - 1;
      check("stall", 32'(stall), 32'(!last));
      check("mem_en", 32'(mem_en), 32'(legal && c == 1));
      if (legal && c == 1) begin
        check("mem_addr", 32'(mem_addr), 32'(a));
        check("mem_wr", 32'(mem_wr), 32'(wr));
        if (wr) check("mem_wdata", 32'(mem_wdata), 32'(d));
      end
      check("err", 32'(err), 32'(last && (!legal || tmo)));
      check("rdata_valid", 32'(rdata_valid), 32'(last && legal && rd && !tmo));
      check("rdata", 32'(rdata), 32'(last ? model_rd : old));
      step;
    end
  endtask

  initial begin
    logic rd, wr;
    logic [15:0] a;
    int kind, sel, k;
    mem_read = 1'b1;
    addr     = 16'h0040;
    repeat (3) step;
    check("rst_stall", 32'(stall), 32'(0));
    check("rst_mem_en", 32'(mem_en), 32'(0));
    check("rst_rdata", 32'(rdata), 32'(0));
    check("rst_mem_addr", 32'(mem_addr), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_rdata_valid", 32'(rdata_valid), 32'(0));
    rst_n = 1'b1;
    #1;
    check("release_stall", 32'(stall), 32'(1));
    run_op(1'b1, 1'b0, 16'h0040, 16'h0000, 0, 16'hBEEF);
    idle(1);
    run_op(1'b0, 1'b1, 16'h0100, 16'h1234, 4, 16'h0000);
    idle(1);
    run_op(1'b1, 1'b0, 16'h0080, 16'h0000, -1, 16'h0000);
    idle(2);
    run_op(1'b1, 1'b0, 16'h0010, 16'h0000, TO, 16'h1357);
    run_op(1'b1, 1'b0, 16'h0041, 16'h0000, 0, 16'h0000);
    idle(1);
    run_op(1'b1, 1'b0, 16'h0012, 16'h0000, TO - 1, 16'h2468);
    run_op(1'b1, 1'b1, 16'h0040, 16'h5555, 0, 16'h0000);
    idle(1);
    mem_read  = 1'b1;
    mem_write = 1'b0;
    addr      = 16'h0200;
    mem_valid = 1'b0;
    repeat (4) step;
    rst_n = 1'b0;
    model_rd = 16'h0000;
    #1;
    check("midrst_stall", 32'(stall), 32'(0));
    check("midrst_mem_en", 32'(mem_en), 32'(0));
    check("midrst_rdata", 32'(rdata), 32'(0));
    check("midrst_mem_addr", 32'(mem_addr), 32'(0));
    check("midrst_mem_wr", 32'(mem_wr), 32'(0));
    check("midrst_err", 32'(err), 32'(0));
    step;
    mem_valid = 1'b1;
    step;
    rst_n = 1'b1;
    mem_read = 1'b0;
    idle(3);
    run_op(1'b1, 1'b0, 16'h0002, 16'h0000, 2, 16'hA5A5);
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 9));
      sel  = int'($urandom_range(0, 9));
      k    = sel == 0 ? -1 : sel == 1 ? TO : int'($urandom_range(0, 6));
      a    = 16'($urandom) & 16'hFFFE;
      rd   = 1'($urandom);
      wr   = ~rd;
      if (kind == 0) begin rd = 1'b1; wr = 1'b1; end
      else if (kind == 1) a[0] = 1'b1;
      run_op(rd, wr, a, 16'($urandom), k, 16'($urandom));
      idle(int'($urandom_range(0, 2)));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
